// File: rtl/mem_bus_arbiter.sv
// Three-way CPU memory port arbiter (DMA > EXEC > FETCH) with two-cycle issue/complete
// transactions and owner bus locking. Define ARB_STARVE_GUARD_EN to add the fetch starvation override.
module mem_bus_arbiter #(
  parameter int REG_WIDTH    = 8,
  parameter int ADDR_WIDTH   = 16,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  phi1,
  input  logic                  reset_n,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_gnt,
  output logic                  fetch_ack,
  input  logic                  exec_req,
  input  logic                  exec_we,
  input  logic                  exec_lock,
  input  logic [ADDR_WIDTH-1:0] exec_addr,
  input  logic [REG_WIDTH-1:0]  exec_wdata,
  output logic                  exec_gnt,
  output logic                  exec_ack,
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic                  dma_lock,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [REG_WIDTH-1:0]  dma_wdata,
  output logic                  dma_gnt,
  output logic                  dma_ack,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [REG_WIDTH-1:0]  mem_wdata,
  input  logic [REG_WIDTH-1:0]  mem_rdata,
  output logic [REG_WIDTH-1:0]  rdata,
  output logic                  arb_starve
);
  localparam int NREQ  = 3;
  localparam int FETCH = 0;
  localparam int EXEC  = 1;
  localparam int DMA   = 2;
  localparam int CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_HOLD = 2'd2} state_t;

  state_t                               state, state_nxt;
  logic [NREQ-1:0]                      req_v, lock_v, we_v, win, sel;
  logic [NREQ-1:0]                      own_q, own_d, ack_q, ack_d;
  logic [NREQ-1:0][ADDR_WIDTH-1:0]      addr_v;
  logic [NREQ-1:0][REG_WIDTH-1:0]       wdata_v;
  logic                                 own_req, own_lock, issue, starve;
  logic                                 mem_en_d, mem_we_d;
  logic [ADDR_WIDTH-1:0]                addr_d;
  logic [REG_WIDTH-1:0]                 wdata_d;
  logic [CW-1:0]                        starve_cnt;

  assign req_v    = {dma_req, exec_req, fetch_req};
  assign lock_v   = {dma_lock, exec_lock, 1'b0};
  assign we_v     = {dma_we, exec_we, 1'b0};
  assign addr_v   = {dma_addr, exec_addr, fetch_addr};
  assign wdata_v  = {dma_wdata, exec_wdata, {REG_WIDTH{1'b0}}};
  assign own_req  = |(own_q & req_v);
  assign own_lock = |(own_q & lock_v);

  assign {dma_gnt, exec_gnt, fetch_gnt} = own_q;
  assign {dma_ack, exec_ack, fetch_ack} = ack_q;

  // Starvation override lets fetch jump the fixed priority order
  always_comb begin
    win = '0;
    if (starve && fetch_req) win[FETCH] = 1'b1;
    else if (dma_req)        win[DMA]   = 1'b1;
    else if (exec_req)       win[EXEC]  = 1'b1;
    else if (fetch_req)      win[FETCH] = 1'b1;
  end

  always_ff @(posedge phi1 or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (|req_v) state_nxt = S_BUSY;
      S_BUSY:  state_nxt = own_lock ? S_HOLD : S_IDLE;
      S_HOLD:  state_nxt = own_req ? S_BUSY : (own_lock ? S_HOLD : S_IDLE);
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered owner/ack/memory strobes
  always_comb begin
    own_d = own_q;
    ack_d = '0;
    issue = 1'b0;
    sel   = own_q;
    case (state)
      S_IDLE: begin
        own_d = win;
        sel   = win;
        issue = |req_v;
      end
      S_BUSY: begin
        ack_d = own_q;
        if (!own_lock) own_d = '0;
      end
      S_HOLD: begin
        issue = own_req;
        if (!own_req && !own_lock) own_d = '0;
      end
      default: own_d = '0;
    endcase
    mem_en_d = issue;
    mem_we_d = issue & |(sel & we_v);
    addr_d   = mem_addr;
    wdata_d  = mem_wdata;
    for (int i = 0; i < NREQ; i++) begin
      if (issue && sel[i]) begin
        addr_d  = addr_v[i];
        wdata_d = wdata_v[i];
      end
    end
  end

  always_ff @(posedge phi1 or negedge reset_n) begin
    if (!reset_n) begin
      own_q     <= '0;
      ack_q     <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
    end else begin
      own_q     <= own_d;
      ack_q     <= ack_d;
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      if (state == S_BUSY) rdata <= mem_rdata;
    end
  end

`ifdef ARB_STARVE_GUARD_EN
  // Counts IDLE arbitrations that fetch lost while still requesting
  always_ff @(posedge phi1 or negedge reset_n) begin
    if (!reset_n)                  starve_cnt <= '0;
    else if (!fetch_req)           starve_cnt <= '0;
    else if (state == S_IDLE) begin
      if (win[FETCH])              starve_cnt <= '0;
      else if (starve_cnt != LIM)  starve_cnt <= starve_cnt + CW'(1);
    end
  end
`else
  assign starve_cnt = '0;
`endif

  assign starve     = (starve_cnt == LIM);
  assign arb_starve = starve;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus random traffic, all outputs
// compared every cycle against a transaction-level reference model.
module tb_mem_bus_arbiter;
  localparam int LIMIT = 8;

  logic        phi1 = 1'b0, reset_n;
  logic        fetch_req, fetch_gnt, fetch_ack;
  logic [15:0] fetch_addr;
  logic        exec_req, exec_we, exec_lock, exec_gnt, exec_ack;
  logic [15:0] exec_addr;
  logic [7:0]  exec_wdata;
  logic        dma_req, dma_we, dma_lock, dma_gnt, dma_ack;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        mem_en, mem_we, arb_starve;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata, rdata;

  int n_chk = 0, n_err = 0;
  bit chk_en = 1'b0;

  mem_bus_arbiter #(.REG_WIDTH(8), .ADDR_WIDTH(16), .STARVE_LIMIT(LIMIT)) dut (
    .phi1(phi1), .reset_n(reset_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt), .fetch_ack(fetch_ack),
    .exec_req(exec_req), .exec_we(exec_we), .exec_lock(exec_lock), .exec_addr(exec_addr),
    .exec_wdata(exec_wdata), .exec_gnt(exec_gnt), .exec_ack(exec_ack),
    .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_ack(dma_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .rdata(rdata), .arb_starve(arb_starve)
  );

  always #5 phi1 = ~phi1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory device: address registered by the arbiter, data sampled at the completion edge
  logic [7:0] dev_mem [0:65535];
  logic [7:0] ref_mem [0:65535];
  assign mem_rdata = dev_mem[mem_addr];
  always @(posedge phi1) if (mem_en && mem_we) dev_mem[mem_addr] = mem_wdata;

  // Reference model: one owner, one access in flight at a time
  int          m_owner = -1;
  bit          m_busy = 1'b0, p_we = 1'b0;
  int          m_cnt = 0;
  logic [7:0]  p_data = '0;
  logic [2:0]  e_gnt = '0, e_ack = '0;
  bit          e_en = 1'b0, e_we = 1'b0, e_rd_ack = 1'b0, e_starve = 1'b0;
  logic [15:0] e_addr = '0;
  logic [7:0]  e_wdata = '0, e_rdata = '0;

  task automatic m_issue(input int i);
    logic [15:0] a;
    logic        w;
    logic [7:0]  d;
    case (i)
      0:       begin a = fetch_addr; w = 1'b0;   d = 8'h00;      end
      1:       begin a = exec_addr;  w = exec_we; d = exec_wdata; end
      default: begin a = dma_addr;   w = dma_we;  d = dma_wdata;  end
    endcase
    m_busy = 1'b1; e_en = 1'b1; e_we = w; e_addr = a; e_wdata = d;
    p_we = w; p_data = ref_mem[a];
    if (w) ref_mem[a] = d;
  endtask

  always @(posedge phi1 or negedge reset_n) begin
    logic [2:0] r, lk;
    int w;
    if (!reset_n) begin
      m_owner = -1; m_busy = 1'b0; m_cnt = 0;
      e_ack = '0; e_en = 1'b0; e_we = 1'b0; e_rd_ack = 1'b0; e_starve = 1'b0;
      e_addr = '0; e_wdata = '0; e_rdata = '0;
    end else begin
      r  = {dma_req, exec_req, fetch_req};
      lk = {dma_lock, exec_lock, 1'b0};
      e_ack = '0; e_en = 1'b0; e_we = 1'b0; e_rd_ack = 1'b0;
      if (m_busy) begin
        m_busy = 1'b0;
        e_ack[m_owner] = 1'b1;
        e_rdata = p_data;
        e_rd_ack = !p_we;
        if (!lk[m_owner]) m_owner = -1;
      end else if (m_owner >= 0) begin
        if (r[m_owner]) m_issue(m_owner);
        else if (!lk[m_owner]) m_owner = -1;
      end else if (r != 3'b000) begin
        w = r[2] ? 2 : (r[1] ? 1 : 0);
`ifdef ARB_STARVE_GUARD_EN
        if (m_cnt >= LIMIT && r[0]) w = 0;
        if (r[0]) m_cnt = (w == 0) ? 0 : ((m_cnt < LIMIT) ? m_cnt + 1 : LIMIT);
`endif
        m_owner = w;
        m_issue(w);
      end
`ifdef ARB_STARVE_GUARD_EN
      if (!r[0]) m_cnt = 0;
      e_starve = (m_cnt >= LIMIT);
`endif
    end
    e_gnt = (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
  end

  always @(negedge phi1) begin
    if (chk_en) begin
      chk("gnt", 32'({dma_gnt, exec_gnt, fetch_gnt}), 32'(e_gnt));
      chk("ack", 32'({dma_ack, exec_ack, fetch_ack}), 32'(e_ack));
      chk("mem_en", 32'(mem_en), 32'(e_en));
      chk("mem_we", 32'(mem_we), 32'(e_we));
      chk("arb_starve", 32'(arb_starve), 32'(e_starve));
      if (e_en) begin
        chk("mem_addr", 32'(mem_addr), 32'(e_addr));
        chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
      end
      if (e_rd_ack) chk("rdata", 32'(rdata), 32'(e_rdata));
    end
  end

  initial begin
    int order, n, bad, stage, got, fgnt_cyc;
    bit seen_starve;
    int t [3];
    reset_n = 1'b0;
    fetch_req = 0; fetch_addr = '0;
    exec_req = 0; exec_we = 0; exec_lock = 0; exec_addr = '0; exec_wdata = '0;
    dma_req = 0; dma_we = 0; dma_lock = 0; dma_addr = '0; dma_wdata = '0;
    for (int a = 0; a < 65536; a++) begin
      dev_mem[a] = 8'(a) ^ 8'(a >> 8);
      ref_mem[a] = 8'(a) ^ 8'(a >> 8);
    end
    chk_en = 1'b1;
    repeat (3) @(negedge phi1);
    chk("rst_gnt", 32'({dma_gnt, exec_gnt, fetch_gnt, dma_ack, exec_ack, fetch_ack}), 32'd0);
    chk("rst_mem", 32'({mem_en, mem_we, mem_addr, mem_wdata}), 32'd0);
    chk("rst_rdata", 32'({rdata, arb_starve}), 32'd0);
    reset_n = 1'b1;
    @(negedge phi1);

    // Reset while an access is in flight
    fetch_req = 1; fetch_addr = 16'h8000;
    @(negedge phi1);
    chk("ma_issue", 32'({fetch_gnt, mem_en}), 32'b11);
    #2 reset_n = 1'b0;
    #1 chk("ma_rst", 32'({fetch_gnt, mem_en}), 32'b00);
    @(negedge phi1);
    chk("ma_no_ack", 32'(fetch_ack), 32'd0);
    reset_n = 1'b1;
    @(negedge phi1);
    chk("ma_reissue", 32'({fetch_gnt, mem_en, mem_addr}), {14'd0, 2'b11, 16'h8000});
    @(negedge phi1);
    chk("ma_ack", 32'(fetch_ack), 32'd1);
    fetch_req = 0;
    @(negedge phi1);

    // Plain fetch read
    dev_mem[16'hC000] = 8'hA9; ref_mem[16'hC000] = 8'hA9;
    fetch_req = 1; fetch_addr = 16'hC000;
    @(negedge phi1);
    chk("fr_issue", 32'({mem_en, mem_addr}), {15'd0, 1'b1, 16'hC000});
    @(negedge phi1);
    chk("fr_ack", 32'({fetch_ack, mem_en, rdata}), {22'd0, 2'b10, 8'hA9});
    fetch_req = 0;
    @(negedge phi1);

    // Three-way collision
    exec_we = 1; exec_addr = 16'h0010; exec_wdata = 8'h55;
    dma_we = 0; dma_addr = 16'h0200; fetch_addr = 16'hC001;
    fetch_req = 1; exec_req = 1; dma_req = 1;
    order = 0; n = 0; t = '{-1, -1, -1};
    for (int c = 0; c < 30 && n < 3; c++) begin
      @(negedge phi1);
      if (dma_ack)   begin order = order * 10 + 2; t[n] = c; n++; dma_req = 0;   end
      if (exec_ack)  begin order = order * 10 + 1; t[n] = c; n++; exec_req = 0;  end
      if (fetch_ack) begin order = order * 10 + 0; t[n] = c; n++; fetch_req = 0; end
    end
    chk("col_count", 32'(n), 32'd3);
    chk("col_order", 32'(order), 32'd210);
    chk("col_gap1", 32'(t[1] - t[0]), 32'd2);
    chk("col_gap2", 32'(t[2] - t[1]), 32'd2);
    chk("col_mem", 32'(dev_mem[16'h0010]), 32'h55);
    exec_we = 0;
    @(negedge phi1);

    // Locked DMA burst with fetch waiting
    dma_lock = 1; dma_req = 1; dma_addr = 16'h0200;
    fetch_req = 1; fetch_addr = 16'hC000;
    n = 0; bad = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge phi1);
      if (!dma_gnt || fetch_gnt) bad++;
      if (dma_ack) begin
        n++;
        if (n < 4) dma_addr = dma_addr + 16'd1;
        else begin dma_req = 0; dma_lock = 0; end
      end
    end
    chk("burst_cnt", 32'(n), 32'd4);
    chk("burst_hold", 32'(bad), 32'd0);
    @(negedge phi1);
    chk("burst_release", 32'({dma_gnt, fetch_gnt}), 32'd0);
    @(negedge phi1);
    chk("burst_fetch", 32'(fetch_gnt), 32'd1);
    @(negedge phi1);
    chk("burst_fack", 32'(fetch_ack), 32'd1);
    fetch_req = 0;
    @(negedge phi1);

    // Executor read-modify-write under lock while DMA waits
    dev_mem[16'h0040] = 8'h3C; ref_mem[16'h0040] = 8'h3C;
    exec_lock = 1; exec_req = 1; exec_we = 0; exec_addr = 16'h0040;
    @(negedge phi1);
    chk("rmw_gnt", 32'(exec_gnt), 32'd1);
    dma_req = 1; dma_we = 0; dma_addr = 16'h0300;
    stage = 0; bad = 0;
    for (int c = 0; c < 20 && stage < 2; c++) begin
      @(negedge phi1);
      if (dma_gnt) bad++;
      if (exec_ack) begin
        if (stage == 0) begin
          chk("rmw_rd", 32'(rdata), 32'h3C);
          exec_we = 1; exec_wdata = 8'h3D; stage = 1;
        end else begin
          exec_req = 0; exec_lock = 0; exec_we = 0; stage = 2;
        end
      end
    end
    chk("rmw_done", 32'(stage), 32'd2);
    chk("rmw_no_dma", 32'(bad), 32'd0);
    got = 0;
    for (int c = 0; c < 10 && got == 0; c++) begin
      @(negedge phi1);
      if (dma_ack) begin got = 1; dma_req = 0; end
    end
    chk("rmw_dma", 32'(got), 32'd1);
    chk("rmw_mem", 32'(dev_mem[16'h0040]), 32'h3D);
    @(negedge phi1);

    // Back-to-back executor traffic against a waiting fetch
    exec_req = 1; exec_we = 0; exec_lock = 0; exec_addr = 16'h0050;
    fetch_req = 1; fetch_addr = 16'hC002;
    seen_starve = 0; fgnt_cyc = -1;
    for (int c = 0; c < 24; c++) begin
      @(negedge phi1);
      if (arb_starve) seen_starve = 1;
      if (fetch_gnt && fgnt_cyc < 0) fgnt_cyc = c;
      if (fetch_ack) fetch_req = 0;
    end
`ifdef ARB_STARVE_GUARD_EN
    chk("starve_flag", 32'(seen_starve), 32'd1);
    chk("starve_gnt_cyc", 32'(fgnt_cyc), 32'd16);
`else
    chk("starve_flag", 32'(seen_starve), 32'd0);
    chk("starve_gnt_cyc", 32'(fgnt_cyc), 32'hFFFF_FFFF);
`endif
    exec_req = 0; fetch_req = 0;
    repeat (4) @(negedge phi1);

    // Random traffic obeying the requester handshake rules
    for (int c = 0; c < 3000; c++) begin
      @(negedge phi1);
      if (fetch_ack || !fetch_req) begin
        fetch_req  = fetch_ack ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) == 0);
        fetch_addr = 16'($urandom_range(0, 63));
      end
      if (exec_ack || !exec_req) begin
        exec_req   = exec_ack ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) == 0);
        exec_we    = 1'($urandom);
        exec_addr  = 16'($urandom_range(0, 63));
        exec_wdata = 8'($urandom);
        exec_lock  = ($urandom_range(0, 2) == 0);
      end
      if (dma_ack || !dma_req) begin
        dma_req   = dma_ack ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 4) == 0);
        dma_we    = 1'($urandom);
        dma_addr  = 16'($urandom_range(0, 63));
        dma_wdata = 8'($urandom);
        dma_lock  = ($urandom_range(0, 2) == 0);
      end
    end
    fetch_req = 0; exec_req = 0; dma_req = 0; exec_lock = 0; dma_lock = 0;
    repeat (6) @(negedge phi1);
    chk("end_idle", 32'({dma_gnt, exec_gnt, fetch_gnt, mem_en}), 32'd0);
    for (int a = 0; a < 64; a++) chk("end_mem", 32'(dev_mem[a]), 32'(ref_mem[a]));
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
